// File: rtl/bcd_entry_encoder_pkg.sv
// Shared definitions for the keypad number-entry block: FSM states, the
// dabble constants and the default geometry.
package bcd_entry_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } entry_state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] DABBLE_THRESH = 4'd8;
    localparam logic [3:0] DABBLE_ADJ    = 4'd3;

    localparam int DEF_DIGITS     = 3;
    localparam int DEF_OUT_W      = 8;
    localparam int DEF_CONV_STEPS = 10;

endpackage

// File: rtl/bcd_shift_step.sv
// One reverse double-dabble iteration: shift {bcd, acc} right by one, then
// pull every BCD nibble that reached 8 back down by 3.
module bcd_shift_step
    import bcd_entry_encoder_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int ACC_W  = DEF_CONV_STEPS
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic [ACC_W-1:0]    acc_in,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [ACC_W-1:0]    acc_out
);

    logic [4*DIGITS-1:0] bcd_sh;

    assign {bcd_sh, acc_out} = {1'b0, bcd_in, acc_in[ACC_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        logic [3:0] nib;
        assign nib = bcd_sh[4*g +: 4];
        assign bcd_out[4*g +: 4] = (nib >= DABBLE_THRESH) ? (nib - DABBLE_ADJ) : nib;
    end

endmodule

// File: rtl/bcd_entry_encoder.sv
// Keypad digit/sign accumulator with a sequential BCD-to-binary conversion
// and a valid/ready result port toward the ALU operand registers.
module bcd_entry_encoder
    import bcd_entry_encoder_pkg::*;
#(
    parameter int DIGITS     = DEF_DIGITS,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int CONV_STEPS = DEF_CONV_STEPS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            key_digit,
    input  logic                  key_stb,
    input  logic                  key_neg,
    input  logic                  key_clr,
    input  logic                  key_ent,
    output logic [4*DIGITS-1:0]   entry_bcd,
    output logic [1:0]            digit_cnt,
    output logic                  busy,
    output logic [OUT_W-1:0]      bin,
    output logic                  sgn,
    output logic                  ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int          BCD_W   = 4*DIGITS;
    localparam int unsigned BIN_MAX = (1 << OUT_W) - 1;

    entry_state_t          state, state_nx;
    logic [3:0]            step_cnt;
    logic [BCD_W-1:0]      sh_bcd, step_bcd;
    logic [CONV_STEPS-1:0] sh_acc, step_acc;
    logic                  sign_r;
    logic                  digit_ok, conv_done, accept, ovf_nx;
    logic [OUT_W-1:0]      bin_nx;

    bcd_shift_step #(.DIGITS(DIGITS), .ACC_W(CONV_STEPS)) u_step (
        .bcd_in  (sh_bcd),
        .acc_in  (sh_acc),
        .bcd_out (step_bcd),
        .acc_out (step_acc)
    );

    assign digit_ok  = key_stb && (key_digit <= BCD_DIGIT_MAX) && (32'(digit_cnt) < DIGITS);
    assign conv_done = (32'(step_cnt) == CONV_STEPS);
    assign accept    = out_valid && out_ready;
    assign ovf_nx    = (32'(sh_acc) > BIN_MAX);
    assign bin_nx    = ovf_nx ? '1 : OUT_W'(sh_acc);

    always_comb begin
        state_nx = state;
        if (key_clr) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (key_ent)   state_nx = CONV;
                CONV:    if (conv_done) state_nx = HOLD;
                HOLD:    if (accept)    state_nx = IDLE;
                default:                state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            step_cnt  <= '0;
            sh_bcd    <= '0;
            sh_acc    <= '0;
            sign_r    <= 1'b0;
            entry_bcd <= '0;
            digit_cnt <= '0;
            bin       <= '0;
            sgn       <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            // Clear aborts everything but leaves the last result on bin/sgn/ovf.
            if (key_clr) begin
                entry_bcd <= '0;
                digit_cnt <= '0;
                sign_r    <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (key_neg) sign_r <= ~sign_r;
                        if (key_ent) begin
                            sh_bcd   <= entry_bcd;
                            sh_acc   <= '0;
                            step_cnt <= '0;
                        end else if (digit_ok) begin
                            entry_bcd <= {entry_bcd[BCD_W-5:0], key_digit};
                            digit_cnt <= digit_cnt + 2'd1;
                        end
                    end
                    CONV: begin
                        if (conv_done) begin
                            bin       <= bin_nx;
                            ovf       <= ovf_nx;
                            sgn       <= sign_r && (bin_nx != '0);
                            out_valid <= 1'b1;
                        end else begin
                            sh_bcd   <= step_bcd;
                            sh_acc   <= step_acc;
                            step_cnt <= step_cnt + 4'd1;
                        end
                    end
                    HOLD: begin
                        if (accept) begin
                            entry_bcd <= '0;
                            digit_cnt <= '0;
                            sign_r    <= 1'b0;
                            out_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_entry_encoder.sv
// Bench for bcd_entry_encoder: table of keyed entries plus hand sequences for
// stall, abort, enter/strobe collision and asynchronous reset.
module tb_bcd_entry_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_digit;
    logic        key_stb, key_neg, key_clr, key_ent;
    logic [11:0] entry_bcd;
    logic [1:0]  digit_cnt;
    logic        busy;
    logic [7:0]  bin;
    logic        sgn, ovf, out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    bcd_entry_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .key_digit (key_digit),
        .key_stb   (key_stb),
        .key_neg   (key_neg),
        .key_clr   (key_clr),
        .key_ent   (key_ent),
        .entry_bcd (entry_bcd),
        .digit_cnt (digit_cnt),
        .busy      (busy),
        .bin       (bin),
        .sgn       (sgn),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct packed {
        logic [7:0] bin;
        logic       sgn;
        logic       ovf;
    } res_t;

    typedef struct {
        int          nkeys;
        logic [19:0] keys;
        logic        neg;
        logic [11:0] exp_entry;
        logic [1:0]  exp_cnt;
        res_t        exp_res;
    } vec_t;

    res_t sb_q[$];
    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the keys are seen by the next posedge.
    task automatic pulse(input logic stb, input logic [3:0] d, input logic neg,
                         input logic ent, input logic clr);
        key_stb = stb; key_digit = d; key_neg = neg; key_ent = ent; key_clr = clr;
        @(negedge clk);
        key_stb = 1'b0; key_digit = 4'd0; key_neg = 1'b0; key_ent = 1'b0; key_clr = 1'b0;
    endtask

    task automatic get_result(input string name);
        int   lat = 0;
        res_t e;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd11);
        if (sb_q.size() == 0) begin
            check({name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({name, " bin"}, 32'(bin), 32'(e.bin));
            check({name, " sgn"}, 32'(sgn), 32'(e.sgn));
            check({name, " ovf"}, 32'(ovf), 32'(e.ovf));
        end
    endtask

    task automatic accept(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " valid drop"}, 32'(out_valid), 32'd0);
        check({name, " entry clr"},  32'(entry_bcd), 32'd0);
        check({name, " cnt clr"},    32'(digit_cnt), 32'd0);
        check({name, " busy low"},   32'(busy),      32'd0);
    endtask

    initial begin
        vecs[0] = '{3, 20'h00721, 1'b0, 12'h127, 2'd3, '{8'h7F, 1'b0, 1'b0}};
        vecs[1] = '{3, 20'h00552, 1'b1, 12'h255, 2'd3, '{8'hFF, 1'b1, 1'b0}};
        vecs[2] = '{3, 20'h00999, 1'b0, 12'h999, 2'd3, '{8'hFF, 1'b0, 1'b1}};
        vecs[3] = '{5, 20'hC4321, 1'b0, 12'h123, 2'd3, '{8'h7B, 1'b0, 1'b0}};
        vecs[4] = '{0, 20'h00000, 1'b1, 12'h000, 2'd0, '{8'h00, 1'b0, 1'b0}};
        vecs[5] = '{3, 20'h00240, 1'b1, 12'h042, 2'd3, '{8'h2A, 1'b1, 1'b0}};
        vecs[6] = '{1, 20'h00006, 1'b1, 12'h006, 2'd1, '{8'h06, 1'b1, 1'b0}};

        rst = 1'b0; out_ready = 1'b0;
        key_stb = 1'b0; key_digit = 4'd0; key_neg = 1'b0; key_ent = 1'b0; key_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outs", 32'({entry_bcd, digit_cnt, busy, bin, sgn, ovf, out_valid}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (vecs[i].neg) pulse(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < vecs[i].nkeys; k++)
                pulse(1'b1, vecs[i].keys[4*k +: 4], 1'b0, 1'b0, 1'b0);
            check({nm, " entry"}, 32'(entry_bcd), 32'(vecs[i].exp_entry));
            check({nm, " cnt"},   32'(digit_cnt), 32'(vecs[i].exp_cnt));
            sb_q.push_back(vecs[i].exp_res);
            pulse(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
            check({nm, " busy"}, 32'(busy), 32'd1);
            get_result(nm);
            accept(nm);
        end

        // Stall in HOLD while keys are hammered.
        pulse(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        sb_q.push_back('{8'd80, 1'b0, 1'b0});
        pulse(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        get_result("stall");
        for (int c = 0; c < 5; c++) begin
            pulse(1'b1, 4'd3, 1'b1, (c % 2) == 0, 1'b0);
            check("stall hold", 32'({out_valid, bin, sgn, ovf}), 32'({1'b1, 8'd80, 1'b0, 1'b0}));
            check("stall entry", 32'({entry_bcd, digit_cnt}), 32'({12'h080, 2'd2}));
        end
        accept("stall");

        // Enter and strobe in the same cycle: the digit is dropped.
        pulse(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        sb_q.push_back('{8'd4, 1'b0, 1'b0});
        pulse(1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
        check("ent+stb entry", 32'(entry_bcd), 32'h004);
        get_result("ent+stb");
        accept("ent+stb");

        // Clear during the 4th conversion cycle.
        begin
            logic saw_valid;
            saw_valid = 1'b0;
            pulse(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
            pulse(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
            pulse(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
            repeat (3) @(negedge clk);
            pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
            check("abort idle", 32'({busy, out_valid}), 32'd0);
            check("abort entry", 32'({entry_bcd, digit_cnt}), 32'd0);
            for (int c = 0; c < 20; c++) begin
                if (out_valid) saw_valid = 1'b1;
                @(negedge clk);
            end
            check("abort no valid", 32'(saw_valid), 32'd0);
            check("abort bin kept", 32'(bin), 32'd4);
        end

        // Asynchronous reset while holding a result.
        pulse(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        sb_q.push_back('{8'd12, 1'b1, 1'b0});
        pulse(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        get_result("rst hold");
        #2 rst = 1'b0;
        #1 check("async rst", 32'({entry_bcd, digit_cnt, busy, bin, sgn, ovf, out_valid}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post rst idle", 32'({busy, out_valid}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
